// File: rtl/deserializador_alineado_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pcie_phy_pkg : symbols and receive FSM states shared by the PHY RX    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pcie_phy_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] IDL_SYM = 8'h7C;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/deserializador_alineado_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | deserializador_alineado_if : serial input and aligned word outputs    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface deserializador_alineado_if #(
  parameter int WIDTH = 8
) ();

  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             word_strobe;
  logic             active_out;
  logic             lock_lost;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  word_strobe,
    input  active_out,
    input  lock_lost
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output word_strobe,
    output active_out,
    output lock_lost
  );

endinterface
`default_nettype wire

// File: rtl/deserializador_alineado_detector_com.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | detector_com : serial shift register with COM / IDL symbol compare    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module detector_com
  import pcie_phy_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] COM   = WIDTH'(COM_SYM),
  parameter logic [WIDTH-1:0] IDL   = WIDTH'(IDL_SYM)
) (
  input  wire logic             clk_32f,
  input  wire logic             reset,
  input  wire logic             data_in,
  output logic [WIDTH-1:0]      sr,
  output logic                  is_com,
  output logic                  is_idl
);

  logic [WIDTH-1:0] r_sr;

  // MSB arrives first, so new bits enter at the LSB end.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      r_sr <= '0;
    end else begin
      r_sr <= {r_sr[WIDTH-2:0], data_in};
    end
  end

  assign sr     = r_sr;
  assign is_com = (r_sr == COM);
  assign is_idl = (r_sr == IDL);

endmodule
`default_nettype wire

// File: rtl/deserializador_alineado.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | deserializador_alineado : COM-aligned serial-to-parallel receiver     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module deserializador_alineado
  import pcie_phy_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM        = WIDTH'(COM_SYM),
  parameter logic [WIDTH-1:0] IDL        = WIDTH'(IDL_SYM),
  parameter int               LOCK_COUNT = 4,
  parameter int               LOSS_COUNT = 4
) (
  input wire logic                clk_32f,
  input wire logic                reset,
  deserializador_alineado_if.slave bus
);

  localparam int c_BIT_W  = $clog2(WIDTH);
  localparam int c_COM_W  = $clog2(LOCK_COUNT + 1);
  localparam int c_MISS_W = $clog2(LOSS_COUNT + 1);

  localparam logic [c_BIT_W-1:0]  c_LAST_BIT = c_BIT_W'(WIDTH - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_ONE  = c_BIT_W'(1);
  localparam logic [c_COM_W-1:0]  c_COM_ONE  = c_COM_W'(1);
  localparam logic [c_COM_W-1:0]  c_LOCK     = c_COM_W'(LOCK_COUNT);
  localparam logic [c_MISS_W-1:0] c_LOSS     = c_MISS_W'(LOSS_COUNT);

  logic [WIDTH-1:0]    w_sr;
  logic                w_is_com;
  logic                w_is_idl;
  logic                w_boundary;
  logic [c_BIT_W-1:0]  w_bit_next;
  logic [c_COM_W-1:0]  w_com_inc;
  logic [c_MISS_W-1:0] w_miss_inc;

  rx_state_t           r_state;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic [c_COM_W-1:0]  r_com_cnt;
  logic [c_MISS_W-1:0] r_miss_cnt;
  logic [WIDTH-1:0]    r_data_out;
  logic                r_valid_out;
  logic                r_word_strobe;
  logic                r_active_out;
  logic                r_lock_lost;

  detector_com #(
    .WIDTH (WIDTH),
    .COM   (COM),
    .IDL   (IDL)
  ) u_detector_com (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (bus.data_in),
    .sr      (w_sr),
    .is_com  (w_is_com),
    .is_idl  (w_is_idl)
  );

  assign w_boundary = (r_bit_cnt == '0);
  assign w_bit_next = (r_bit_cnt == c_LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
  assign w_com_inc  = r_com_cnt + 1'b1;
  assign w_miss_inc = (r_miss_cnt == c_LOSS) ? c_LOSS : r_miss_cnt + 1'b1;

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      r_state       <= SEARCH;
      r_bit_cnt     <= '0;
      r_com_cnt     <= '0;
      r_miss_cnt    <= '0;
      r_data_out    <= '0;
      r_valid_out   <= 1'b0;
      r_word_strobe <= 1'b0;
      r_active_out  <= 1'b0;
      r_lock_lost   <= 1'b0;
    end else begin
      r_word_strobe <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_bit_cnt     <= w_bit_next;
      case (r_state)
        SEARCH: begin
          // sr holds a full COM now, so the next boundary is WIDTH-1 cycles out.
          if (w_is_com) begin
            r_bit_cnt  <= c_BIT_ONE;
            r_com_cnt  <= c_COM_ONE;
            r_miss_cnt <= '0;
            if (LOCK_COUNT == 1) begin
              r_state      <= LOCKED;
              r_active_out <= 1'b1;
            end else begin
              r_state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (w_boundary) begin
            if (w_is_com) begin
              r_com_cnt <= w_com_inc;
              if (w_com_inc == c_LOCK) begin
                r_state      <= LOCKED;
                r_active_out <= 1'b1;
                r_miss_cnt   <= '0;
              end
            end else begin
              r_state   <= SEARCH;
              r_com_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          if (w_boundary) begin
            r_word_strobe <= 1'b1;
            if (w_is_com) begin
              r_valid_out <= 1'b0;
              r_miss_cnt  <= '0;
            end else if (w_is_idl) begin
              r_valid_out <= 1'b0;
            end else begin
              r_data_out  <= w_sr;
              r_valid_out <= 1'b1;
            end
          end else if (w_is_com) begin
            // A COM off the word grid means the transmitter has slipped.
            if (w_miss_inc == c_LOSS) begin
              r_state      <= SEARCH;
              r_active_out <= 1'b0;
              r_valid_out  <= 1'b0;
              r_lock_lost  <= 1'b1;
              r_bit_cnt    <= '0;
              r_com_cnt    <= '0;
              r_miss_cnt   <= '0;
            end else begin
              r_miss_cnt <= w_miss_inc;
            end
          end
        end
        default: begin
          r_state <= SEARCH;
        end
      endcase
    end
  end

  assign bus.data_out    = r_data_out;
  assign bus.valid_out   = r_valid_out;
  assign bus.word_strobe = r_word_strobe;
  assign bus.active_out  = r_active_out;
  assign bus.lock_lost   = r_lock_lost;

endmodule
`default_nettype wire

// File: tb/tb_deserializador_alineado.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_deserializador_alineado : directed bench, 8-bit and 10-bit DUTs    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_deserializador_alineado;

  logic clk_32f = 1'b0;
  logic reset   = 1'b0;

  always #5 clk_32f = ~clk_32f;

  deserializador_alineado_if #(.WIDTH(8))  ifa ();
  deserializador_alineado_if #(.WIDTH(10)) ifb ();

  deserializador_alineado dut_a (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (ifa)
  );

  deserializador_alineado #(
    .WIDTH      (10),
    .COM        (10'h17C),
    .IDL        (10'h07C),
    .LOCK_COUNT (1),
    .LOSS_COUNT (4)
  ) dut_b (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (ifb)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int lost_cnt = 0;
  int last_strobe_cyc = 0;
  int strobe_gap = 0;

  logic [9:0] s_data;
  logic       s_valid, s_strobe, s_active, s_lost;

  always @(posedge clk_32f) cyc++;

  // Observed 2 time units after each edge, clear of the negedge drive point.
  always @(posedge clk_32f) begin
    #2;
    if (ifa.word_strobe === 1'b1) begin
      strobe_gap      = cyc - last_strobe_cyc;
      last_strobe_cyc = cyc;
      strobe_cnt++;
    end
    if (ifa.lock_lost === 1'b1) lost_cnt++;
  end

  // Snapshot at the second bit reflects the symbol sent just before this one.
  task automatic send_bits(input logic [9:0] v, input int n, input bit to_b);
    for (int k = n - 1; k >= 0; k--) begin
      @(negedge clk_32f);
      if (k == n - 2) begin
        if (to_b) begin
          s_data = ifb.data_out; s_valid = ifb.valid_out; s_strobe = ifb.word_strobe;
          s_active = ifb.active_out; s_lost = ifb.lock_lost;
        end else begin
          s_data = {2'b00, ifa.data_out}; s_valid = ifa.valid_out; s_strobe = ifa.word_strobe;
          s_active = ifa.active_out; s_lost = ifa.lock_lost;
        end
      end
      if (to_b) ifb.data_in = v[k];
      else      ifa.data_in = v[k];
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_32f);
      ifa.data_in = 1'($urandom_range(1));
      ifb.data_in = 1'($urandom_range(1));
    end
    checks++; if (ifa.data_out !== 8'h00) begin errors++; $display("FAIL rst_a_data: got %h want 00", ifa.data_out); end
    checks++; if (ifa.valid_out !== 1'b0) begin errors++; $display("FAIL rst_a_valid: got %b want 0", ifa.valid_out); end
    checks++; if (ifa.word_strobe !== 1'b0) begin errors++; $display("FAIL rst_a_strobe: got %b want 0", ifa.word_strobe); end
    checks++; if (ifa.active_out !== 1'b0) begin errors++; $display("FAIL rst_a_active: got %b want 0", ifa.active_out); end
    checks++; if (ifa.lock_lost !== 1'b0) begin errors++; $display("FAIL rst_a_lost: got %b want 0", ifa.lock_lost); end
    checks++; if (ifb.data_out !== 10'h000) begin errors++; $display("FAIL rst_b_data: got %h want 000", ifb.data_out); end
    checks++; if (ifb.valid_out !== 1'b0) begin errors++; $display("FAIL rst_b_valid: got %b want 0", ifb.valid_out); end
    checks++; if (ifb.active_out !== 1'b0) begin errors++; $display("FAIL rst_b_active: got %b want 0", ifb.active_out); end
    checks++; if (strobe_cnt !== 0) begin errors++; $display("FAIL rst_strobe_count: got %0d want 0", strobe_cnt); end
    ifa.data_in = 1'b0;
    ifb.data_in = 1'b0;
    @(negedge clk_32f);
    reset = 1'b1;
  endtask

  task automatic test_lock_offset();
    send_bits(10'($urandom_range(7)), 3, 1'b0);
    repeat (3) send_bits(10'h0BC, 8, 1'b0);
    send_bits(10'h0BC, 8, 1'b0);
    checks++; if (s_active !== 1'b0) begin errors++; $display("FAIL lock_early: active got %b want 0 after 3 COM", s_active); end
    send_bits(10'h05A, 8, 1'b0);
    checks++; if (s_active !== 1'b1) begin errors++; $display("FAIL lock_active: got %b want 1", s_active); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL lock_valid_on_com: got %b want 0", s_valid); end
    checks++; if (s_strobe !== 1'b0) begin errors++; $display("FAIL lock_first_strobe: got %b want 0", s_strobe); end
  endtask

  task automatic test_filtering();
    int s0;
    s0 = strobe_cnt;
    send_bits(10'h0A5, 8, 1'b0);
    checks++; if (s_data !== 10'h05A || s_valid !== 1'b1) begin errors++; $display("FAIL filt_5a: data %h valid %b want 05a 1", s_data, s_valid); end
    checks++; if (s_strobe !== 1'b1) begin errors++; $display("FAIL filt_strobe: got %b want 1", s_strobe); end
    send_bits(10'h07C, 8, 1'b0);
    checks++; if (s_data !== 10'h0A5 || s_valid !== 1'b1) begin errors++; $display("FAIL filt_a5: data %h valid %b want 0a5 1", s_data, s_valid); end
    send_bits(10'h0BC, 8, 1'b0);
    checks++; if (s_data !== 10'h0A5 || s_valid !== 1'b0) begin errors++; $display("FAIL filt_idl: data %h valid %b want 0a5 0", s_data, s_valid); end
    send_bits(10'h03C, 8, 1'b0);
    checks++; if (s_data !== 10'h0A5 || s_valid !== 1'b0) begin errors++; $display("FAIL filt_com: data %h valid %b want 0a5 0", s_data, s_valid); end
    send_bits(10'h000, 8, 1'b0);
    checks++; if (s_data !== 10'h03C || s_valid !== 1'b1) begin errors++; $display("FAIL filt_3c: data %h valid %b want 03c 1", s_data, s_valid); end
    checks++; if (strobe_cnt - s0 !== 5) begin errors++; $display("FAIL strobe_count: got %0d want 5", strobe_cnt - s0); end
    checks++; if (strobe_gap !== 8) begin errors++; $display("FAIL strobe_period: got %0d want 8", strobe_gap); end
  endtask

  task automatic test_loss_of_lock();
    int l0;
    l0 = lost_cnt;
    send_bits(10'h000, 3, 1'b0);
    send_bits(10'h0BC, 8, 1'b0);
    send_bits(10'h0BC, 8, 1'b0);
    checks++; if (s_data !== 10'h017 || s_valid !== 1'b1) begin errors++; $display("FAIL loss_slip_word: data %h valid %b want 017 1", s_data, s_valid); end
    send_bits(10'h0BC, 8, 1'b0);
    send_bits(10'h0BC, 8, 1'b0);
    checks++; if (s_active !== 1'b1) begin errors++; $display("FAIL loss_early: active got %b want 1 after 3 misses", s_active); end
    send_bits(10'h0BC, 8, 1'b0);
    checks++; if (s_active !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL loss_outputs: active %b valid %b want 0 0", s_active, s_valid); end
    checks++; if (s_lost !== 1'b1) begin errors++; $display("FAIL loss_pulse: got %b want 1", s_lost); end
    repeat (3) send_bits(10'h0BC, 8, 1'b0);
    checks++; if (lost_cnt - l0 !== 1) begin errors++; $display("FAIL loss_pulse_count: got %0d want 1", lost_cnt - l0); end
    send_bits(10'h066, 8, 1'b0);
    checks++; if (s_active !== 1'b1) begin errors++; $display("FAIL relock_active: got %b want 1", s_active); end
    send_bits(10'h000, 8, 1'b0);
    checks++; if (s_data !== 10'h066 || s_valid !== 1'b1) begin errors++; $display("FAIL relock_data: data %h valid %b want 066 1", s_data, s_valid); end
  endtask

  task automatic test_reset_mid_lock();
    send_bits(10'h016, 5, 1'b0);
    @(negedge clk_32f);
    reset = 1'b0;
    repeat (2) @(negedge clk_32f);
    checks++; if (ifa.active_out !== 1'b0 || ifa.valid_out !== 1'b0) begin errors++; $display("FAIL midrst_flags: active %b valid %b want 0 0", ifa.active_out, ifa.valid_out); end
    checks++; if (ifa.data_out !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", ifa.data_out); end
    ifa.data_in = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_broken_alignment();
    send_bits(10'h0BC, 8, 1'b0);
    send_bits(10'h0BC, 8, 1'b0);
    send_bits(10'h012, 8, 1'b0);
    send_bits(10'h0BC, 8, 1'b0);
    send_bits(10'h0BC, 8, 1'b0);
    send_bits(10'h0BC, 8, 1'b0);
    checks++; if (s_active !== 1'b0) begin errors++; $display("FAIL broken_after_2: active got %b want 0", s_active); end
    send_bits(10'h0BC, 8, 1'b0);
    checks++; if (s_active !== 1'b0) begin errors++; $display("FAIL broken_after_3: active got %b want 0", s_active); end
    send_bits(10'h081, 8, 1'b0);
    checks++; if (s_active !== 1'b1) begin errors++; $display("FAIL broken_lock: active got %b want 1", s_active); end
    send_bits(10'h000, 8, 1'b0);
    checks++; if (s_data !== 10'h081 || s_valid !== 1'b1) begin errors++; $display("FAIL broken_data: data %h valid %b want 081 1", s_data, s_valid); end
  endtask

  task automatic test_param_sweep();
    send_bits(10'h003, 2, 1'b1);
    send_bits(10'h17C, 10, 1'b1);
    send_bits(10'h2A5, 10, 1'b1);
    checks++; if (s_active !== 1'b1 || s_valid !== 1'b0) begin errors++; $display("FAIL w10_lock: active %b valid %b want 1 0", s_active, s_valid); end
    send_bits(10'h155, 10, 1'b1);
    checks++; if (s_data !== 10'h2A5 || s_valid !== 1'b1) begin errors++; $display("FAIL w10_data1: data %h valid %b want 2a5 1", s_data, s_valid); end
    checks++; if (s_strobe !== 1'b1) begin errors++; $display("FAIL w10_strobe: got %b want 1", s_strobe); end
    send_bits(10'h000, 10, 1'b1);
    checks++; if (s_data !== 10'h155 || s_valid !== 1'b1) begin errors++; $display("FAIL w10_data2: data %h valid %b want 155 1", s_data, s_valid); end
  endtask

  initial begin
    ifa.data_in = 1'b0;
    ifb.data_in = 1'b0;
    test_reset();
    test_lock_offset();
    test_filtering();
    test_loss_of_lock();
    test_reset_mid_lock();
    test_broken_alignment();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
